// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM access path.
package slc3_mem_pkg;

  // Default and largest supported number of ACCESS cycles per SRAM cycle.
  localparam int unsigned WAIT_STATES_DEFAULT = 2;
  localparam int unsigned WAIT_STATES_MAX     = 7;

  // Access sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold,
    StDone
  } mem_state_e;

  // Number of ACCESS cycles for an operation: writes always need at least one
  // cycle with the write strobe low, reads may skip ACCESS entirely.
  function automatic logic [2:0] access_cycles(input logic is_write,
                                               input int unsigned wait_states);
    logic [2:0] cycles;
    cycles = 3'(wait_states);
    if (is_write && (cycles == 3'd0)) begin
      cycles = 3'd1;
    end
    return cycles;
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// 3-bit down counter that times the ACCESS phase of an SRAM cycle.
module sram_wait_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       dec_i,
  output logic [2:0] count_o
);

  logic [2:0] count_q, count_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: turns level read/write requests from the control
// unit into one timed asynchronous-SRAM cycle each, with a one-cycle Ack.
module sram_access_ctrl
  import slc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Rd,
  input  logic        Req_Wr,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  output logic [15:0] Data_to_CPU,
  output logic        Ack,
  output logic        Busy,
  output logic [15:0] SRAM_ADDR,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM
);

  localparam int unsigned WaitClamped =
      (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam logic [2:0] RdWaitCycles = access_cycles(1'b0, WaitClamped);
  localparam logic [2:0] WrWaitCycles = access_cycles(1'b1, WaitClamped);

  mem_state_e  state_q, state_d;
  logic        op_wr_q, op_wr_d;
  logic        armed_q, armed_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic        accept;
  logic        cnt_load;
  logic        cnt_dec;
  logic [2:0]  cnt_load_val;
  logic [2:0]  cnt_count;
  logic        cnt_last;

  sram_wait_counter u_wait_counter (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .count_o    (cnt_count)
  );

  assign cnt_last = (cnt_count == 3'd1);

  // A request is taken only from IDLE and only once per request level.
  assign accept = (state_q == StIdle) && armed_q && (Req_Rd || Req_Wr);

  // Next-state, latch and counter-control decode.
  always_comb begin
    state_d      = state_q;
    op_wr_d      = op_wr_q;
    armed_d      = armed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = op_wr_q ? WrWaitCycles : RdWaitCycles;

    // Re-arm whenever both request levels are low; cannot coincide with accept.
    if (!Req_Rd && !Req_Wr) begin
      armed_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StSetup;
          op_wr_d = Req_Wr;  // write wins when both requests are high
          armed_d = 1'b0;
          addr_d  = ADDR;
          if (Req_Wr) begin
            wdata_d = Data_from_CPU;
          end
        end
      end

      StSetup: begin
        cnt_load = 1'b1;
        if (op_wr_q || (RdWaitCycles != 3'd0)) begin
          state_d = StAccess;
        end else begin
          // Zero-wait read: SETUP is the only OE cycle, capture on leaving it.
          state_d = StDone;
          rdata_d = Data_from_SRAM;
        end
      end

      StAccess: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          if (op_wr_q) begin
            state_d = StHold;
          end else begin
            state_d = StDone;
            rdata_d = Data_from_SRAM;
          end
        end
      end

      StHold: begin
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset overrides any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      op_wr_q <= 1'b0;
      armed_q <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      armed_q <= armed_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode from registered state only, so requests never reach them
  // combinationally; op_wr_q selects exactly one strobe, keeping them exclusive.
  always_comb begin
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    if (!op_wr_q && ((state_q == StSetup) || (state_q == StAccess))) begin
      SRAM_OE_N = 1'b0;
    end
    if (op_wr_q && (state_q == StAccess)) begin
      SRAM_WE_N = 1'b0;
    end
  end

  assign Busy         = (state_q != StIdle);
  assign Ack          = (state_q == StDone);
  assign SRAM_ADDR    = addr_q;
  assign Data_to_SRAM = wdata_q;
  assign Data_to_CPU  = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: two instances (WAIT_STATES=2 and 0) share one
// stimulus stream and are each compared against a cycle-count reference model.
module tb_sram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst, rd, wr;
  logic [15:0] addr, din, sram;

  logic [15:0] dtc2, sa2, dts2, dtc0, sa0, dts0;
  logic        ack2, busy2, oe2, we2, ack0, busy0, oe0, we0;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  sram_access_ctrl #(.WAIT_STATES(2)) dut2 (
    .Clk(clk), .Reset(rst), .Req_Rd(rd), .Req_Wr(wr), .ADDR(addr),
    .Data_from_CPU(din), .Data_to_CPU(dtc2), .Ack(ack2), .Busy(busy2),
    .SRAM_ADDR(sa2), .SRAM_OE_N(oe2), .SRAM_WE_N(we2), .Data_to_SRAM(dts2),
    .Data_from_SRAM(sram)
  );

  sram_access_ctrl #(.WAIT_STATES(0)) dut0 (
    .Clk(clk), .Reset(rst), .Req_Rd(rd), .Req_Wr(wr), .ADDR(addr),
    .Data_from_CPU(din), .Data_to_CPU(dtc0), .Ack(ack0), .Busy(busy0),
    .SRAM_ADDR(sa0), .SRAM_OE_N(oe0), .SRAM_WE_N(we0), .Data_to_SRAM(dts0),
    .Data_from_SRAM(sram)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // k counts cycles since the accepting edge (0 = idle); every output is a
  // function of k, the operation and the wait-state count.
  typedef struct {
    int          k;
    bit          wr;
    bit          armed;
    logic [15:0] addr;
    logic [15:0] dts;
    logic [15:0] dtc;
  } model_t;

  model_t m2, m0;

  function automatic int wr_access(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int latency(input bit is_wr, input int w);
    return is_wr ? (wr_access(w) + 3) : (w + 2);
  endfunction

  function automatic model_t step(input model_t m, input int w, input bit r, input bit q_rd,
                                  input bit q_wr, input logic [15:0] a, input logic [15:0] d,
                                  input logic [15:0] s);
    model_t n;
    n = m;
    if (r) begin
      n.k = 0; n.wr = 1'b0; n.armed = 1'b0;
      n.addr = 16'h0; n.dts = 16'h0; n.dtc = 16'h0;
      return n;
    end
    if (m.k != 0) begin
      if (!m.wr && (m.k == w + 1)) n.dtc = s;
      n.k = (m.k == latency(m.wr, w)) ? 0 : m.k + 1;
    end else if (m.armed && (q_rd || q_wr)) begin
      n.k = 1; n.wr = q_wr; n.addr = a; n.armed = 1'b0;
      if (q_wr) n.dts = d;
    end
    if (!q_rd && !q_wr) n.armed = 1'b1;
    return n;
  endfunction

  always @(posedge clk) begin
    m2 <= step(m2, 2, rst, rd, wr, addr, din, sram);
    m0 <= step(m0, 0, rst, rd, wr, addr, din, sram);
  end

  task automatic cmp_dut(input string tag, input int w, input model_t m, input logic busy,
                         input logic ack, input logic oe_n, input logic we_n,
                         input logic [15:0] sa, input logic [15:0] dts, input logic [15:0] dtc);
    bit e_busy, e_ack, e_oe_n, e_we_n;
    e_busy = (m.k != 0);
    e_ack  = (m.k != 0) && (m.k == latency(m.wr, w));
    e_oe_n = !((m.k != 0) && !m.wr && (m.k <= w + 1));
    e_we_n = !((m.k != 0) && m.wr && (m.k >= 2) && (m.k <= wr_access(w) + 1));
    check({tag, ".busy"}, {15'b0, busy}, {15'b0, e_busy});
    check({tag, ".ack"}, {15'b0, ack}, {15'b0, e_ack});
    check({tag, ".oe_n"}, {15'b0, oe_n}, {15'b0, e_oe_n});
    check({tag, ".we_n"}, {15'b0, we_n}, {15'b0, e_we_n});
    check({tag, ".strobes_not_both_low"}, {15'b0, (oe_n | we_n)}, 16'd1);
    check({tag, ".sram_addr"}, sa, m.addr);
    check({tag, ".data_to_sram"}, dts, m.dts);
    check({tag, ".data_to_cpu"}, dtc, m.dtc);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("model_w2", 2, m2, busy2, ack2, oe2, we2, sa2, dts2, dtc2);
      cmp_dut("model_w0", 0, m0, busy0, ack0, oe0, we0, sa0, dts0, dtc0);
    end
  end

  // ---------------- directed table (checked on the WAIT_STATES=2 instance) ----------------
  typedef struct {
    bit          rd, wr;
    logic [15:0] addr, din, sram;
    bit          oe_n, we_n, ack, busy;
    logic [15:0] sa, dts, dtc;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit w, input logic [15:0] a,
                              input logic [15:0] d, input logic [15:0] s, input bit oe_n,
                              input bit we_n, input bit ack, input bit busy,
                              input logic [15:0] sa, input logic [15:0] dts,
                              input logic [15:0] dtc);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.din = d; v.sram = s;
    v.oe_n = oe_n; v.we_n = we_n; v.ack = ack; v.busy = busy;
    v.sa = sa; v.dts = dts; v.dtc = dtc;
    return v;
  endfunction

  vec_t tbl[24];

  task automatic measure0(input bit do_wr, output int ack_lat, output int we_low);
    rd = !do_wr; wr = do_wr; addr = 16'h0099; din = 16'h9999; sram = 16'h4242;
    ack_lat = -1;
    we_low  = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      if (!we0) we_low++;
      if (ack0 && (ack_lat < 0)) ack_lat = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks2, acks0, lat, wl, waited;
    bit any_busy;

    //            rd wr addr      din       sram      oe we ak by sa        dts       dtc
    tbl[0]  = mk(1, 0, 16'h0012, 16'h0000, 16'hBEEF, 0, 1, 0, 1, 16'h0012, 16'h0000, 16'h0000);
    tbl[1]  = mk(0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 1, 0, 1, 16'h0012, 16'h0000, 16'h0000);
    tbl[2]  = mk(0, 0, 16'h0000, 16'h0000, 16'hBEEF, 0, 1, 0, 1, 16'h0012, 16'h0000, 16'h0000);
    tbl[3]  = mk(0, 0, 16'h0000, 16'h0000, 16'hBEEF, 1, 1, 1, 1, 16'h0012, 16'h0000, 16'hBEEF);
    tbl[4]  = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0012, 16'h0000, 16'hBEEF);
    tbl[5]  = mk(0, 1, 16'h0030, 16'h1234, 16'hDEAD, 1, 1, 0, 1, 16'h0030, 16'h1234, 16'hBEEF);
    tbl[6]  = mk(0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 0, 0, 1, 16'h0030, 16'h1234, 16'hBEEF);
    tbl[7]  = mk(0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 0, 0, 1, 16'h0030, 16'h1234, 16'hBEEF);
    tbl[8]  = mk(0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 1, 0, 1, 16'h0030, 16'h1234, 16'hBEEF);
    tbl[9]  = mk(0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 1, 1, 1, 16'h0030, 16'h1234, 16'hBEEF);
    tbl[10] = mk(0, 0, 16'h0000, 16'h0000, 16'hDEAD, 1, 1, 0, 0, 16'h0030, 16'h1234, 16'hBEEF);
    tbl[11] = mk(1, 1, 16'h0044, 16'h5555, 16'h1111, 1, 1, 0, 1, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[12] = mk(1, 1, 16'h0000, 16'h0000, 16'h1111, 1, 0, 0, 1, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[13] = mk(1, 1, 16'h0000, 16'h0000, 16'h1111, 1, 0, 0, 1, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[14] = mk(1, 1, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0, 1, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[15] = mk(1, 1, 16'h0000, 16'h0000, 16'h1111, 1, 1, 1, 1, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[16] = mk(1, 1, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0, 0, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[17] = mk(1, 1, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0, 0, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[18] = mk(0, 0, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0, 0, 16'h0044, 16'h5555, 16'hBEEF);
    tbl[19] = mk(1, 0, 16'h0050, 16'h0000, 16'hCAFE, 0, 1, 0, 1, 16'h0050, 16'h5555, 16'hBEEF);
    tbl[20] = mk(0, 0, 16'h0000, 16'h0000, 16'hCAFE, 0, 1, 0, 1, 16'h0050, 16'h5555, 16'hBEEF);
    tbl[21] = mk(0, 0, 16'h0000, 16'h0000, 16'hCAFE, 0, 1, 0, 1, 16'h0050, 16'h5555, 16'hBEEF);
    tbl[22] = mk(0, 0, 16'h0000, 16'h0000, 16'hCAFE, 1, 1, 1, 1, 16'h0050, 16'h5555, 16'hCAFE);
    tbl[23] = mk(0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h0050, 16'h5555, 16'hCAFE);

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0; din = 16'h0; sram = 16'h0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset.busy", {15'b0, busy2}, 16'd0);
    check("reset.ack", {15'b0, ack2}, 16'd0);
    check("reset.oe_n", {15'b0, oe2}, 16'd1);
    check("reset.we_n", {15'b0, we2}, 16'd1);
    check("reset.sram_addr", sa2, 16'h0000);
    check("reset.data_to_sram", dts2, 16'h0000);
    check("reset.data_to_cpu", dtc2, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rd = tbl[i].rd; wr = tbl[i].wr; addr = tbl[i].addr; din = tbl[i].din; sram = tbl[i].sram;
      @(negedge clk);
      check($sformatf("tbl[%0d].oe_n", i), {15'b0, oe2}, {15'b0, tbl[i].oe_n});
      check($sformatf("tbl[%0d].we_n", i), {15'b0, we2}, {15'b0, tbl[i].we_n});
      check($sformatf("tbl[%0d].ack", i), {15'b0, ack2}, {15'b0, tbl[i].ack});
      check($sformatf("tbl[%0d].busy", i), {15'b0, busy2}, {15'b0, tbl[i].busy});
      check($sformatf("tbl[%0d].sram_addr", i), sa2, tbl[i].sa);
      check($sformatf("tbl[%0d].data_to_sram", i), dts2, tbl[i].dts);
      check($sformatf("tbl[%0d].data_to_cpu", i), dtc2, tbl[i].dtc);
    end

    // Held read request: one access only; a one-cycle drop re-arms.
    rd = 1'b1; addr = 16'h0101; sram = 16'h7E57;
    acks2 = 0; acks0 = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack2) acks2++;
      if (ack0) acks0++;
    end
    check("held_rd.acks_w2", 16'(acks2), 16'd1);
    check("held_rd.acks_w0", 16'(acks0), 16'd1);
    rd = 1'b0;
    @(negedge clk);
    rd = 1'b1;
    waited = 0;
    while (!ack2 && (waited < 10)) begin
      @(negedge clk);
      waited++;
    end
    check("rearm.second_ack_w2", {15'b0, ack2}, 16'd1);
    rd = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the middle of a write, with the request held through it.
    wr = 1'b1; addr = 16'h0077; din = 16'h7777;
    repeat (2) @(negedge clk);
    check("abort.we_low_in_access", {15'b0, we2}, 16'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort.we_n", {15'b0, we2}, 16'd1);
    check("abort.busy", {15'b0, busy2}, 16'd0);
    check("abort.ack", {15'b0, ack2}, 16'd0);
    rst = 1'b0;
    any_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy2 || busy0) any_busy = 1'b1;
    end
    check("abort.no_access_while_held", {15'b0, any_busy}, 16'd0);
    wr = 1'b0;
    @(negedge clk);
    wr = 1'b1;
    @(negedge clk);
    check("abort.access_after_drop", {15'b0, busy2}, 16'd1);
    wr = 1'b0;
    repeat (8) @(negedge clk);

    // Zero-wait-state latencies.
    measure0(1'b0, lat, wl);
    check("w0.read_ack_latency", 16'(lat), 16'd2);
    measure0(1'b1, lat, wl);
    check("w0.write_ack_latency", 16'(lat), 16'd4);
    check("w0.write_we_low_cycles", 16'(wl), 16'd1);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      rd   = ($urandom_range(0, 9) < 4);
      wr   = ($urandom_range(0, 9) < 3);
      addr = 16'($urandom);
      din  = 16'($urandom);
      sram = 16'($urandom);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 The block SHALL have one parameter: WAIT_STATES, default 2, number of ACCESS cycles per SRAM cycle (legal range 0..7).
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  reset, synchronous, active-high.
REQ-004 Req_Rd  input  1  level read request from the control unit.
REQ-005 Req_Wr  input  1  level write request from the control unit.
REQ-006 ADDR  input  16  CPU address, taken from MAR.
REQ-007 Data_from_CPU  input  16  write data, taken from MDR.
REQ-008 Data_to_CPU  output  16  read data, fed to the MDR input mux.
REQ-009 Ack  output  1  one-cycle completion pulse.
REQ-010 Busy  output  1  high in every state except IDLE.
REQ-011 SRAM_ADDR  output  16  latched SRAM address.
REQ-012 SRAM_OE_N  output  1  SRAM output enable, active-low.
REQ-013 SRAM_WE_N  output  1  SRAM write enable, active-low.
REQ-014 Data_to_SRAM  output  16  latched write data.
REQ-015 Data_from_SRAM  input  16  SRAM read data.

Function
REQ-016 States SHALL be IDLE, SETUP, ACCESS, HOLD and DONE.
REQ-017 The block SHALL accept a request only in IDLE and only while the internal armed flag is 1.
REQ-018 Armed SHALL clear on acceptance.
REQ-019 Armed SHALL set on any edge where Req_Rd=0 and Req_Wr=0, so a held level request performs exactly one access.
REQ-020 If Req_Rd and Req_Wr are both high at acceptance, the block SHALL perform a write (write priority).
REQ-021 At acceptance the block SHALL latch ADDR into SRAM_ADDR and the operation type; on writes it SHALL also latch Data_from_CPU into Data_to_SRAM.
REQ-022 SRAM_ADDR and Data_to_SRAM SHALL then hold until the next acceptance.
REQ-023 Read path: IDLE -> SETUP (1 cycle, SRAM_OE_N=0) -> ACCESS (WAIT_STATES cycles, SRAM_OE_N=0; skipped when WAIT_STATES=0) -> DONE.
REQ-024 On a read, Data_from_SRAM SHALL be captured into Data_to_CPU on the edge that leaves the last OE-asserted cycle.
REQ-025 Write path: IDLE -> SETUP (1 cycle, both strobes high) -> ACCESS (max(WAIT_STATES,1) cycles, SRAM_WE_N=0) -> HOLD (1 cycle, SRAM_WE_N=1, data still driven) -> DONE.
REQ-026 DONE SHALL last 1 cycle with Ack=1, then go to IDLE.
REQ-027 Read latency from the accepting edge to Ack high SHALL be WAIT_STATES+2 cycles.
REQ-028 Write latency from the accepting edge to Ack high SHALL be max(WAIT_STATES,1)+3 cycles.
REQ-029 Data_to_CPU SHALL change only on read capture; writes SHALL leave it unchanged.
REQ-030 SRAM_OE_N and SRAM_WE_N SHALL never both be 0.
REQ-031 Both strobes SHALL be 1 in IDLE, HOLD and DONE.
REQ-032 Requests arriving while Busy=1 SHALL be ignored; they do not queue.
REQ-033 The wait counter SHALL be 3 bits, load on SETUP exit, and decrement in ACCESS; it SHALL leave ACCESS at count 1.

Reset
REQ-034 Reset SHALL be synchronous, active-high, and win over every other event, including mid-access.
REQ-035 Reset SHALL return the block to IDLE on the same edge it is sampled.
REQ-036 Reset values SHALL be: SRAM_OE_N=1, SRAM_WE_N=1, Ack=0, Busy=0, SRAM_ADDR=0, Data_to_SRAM=0, Data_to_CPU=0, counter=0, armed=0.
REQ-037 An aborted write SHALL deassert SRAM_WE_N on the reset edge.
REQ-038 Because armed resets to 0, a request held through reset SHALL NOT start an access until it is dropped for at least one cycle.

Structure
REQ-039 Package slc3_mem_pkg SHALL hold the state enum type and the WAIT_STATES default and maximum constants.
REQ-040 The wait counter SHALL be one sub-module, sram_wait_counter (load, decrement, count outputs); everything else stays in one FSM module.
REQ-041 No latches and no combinational path from Req_Rd or Req_Wr to the SRAM strobes SHALL exist; strobes are registered or decoded from state only.

Verification
REQ-042 With WAIT_STATES=2, pulse Req_Rd at ADDR=0x0012 with SRAM returning 0xBEEF -> SRAM_OE_N low for 3 cycles, Ack high on cycle 4 after acceptance, Data_to_CPU=0xBEEF.
REQ-043 With WAIT_STATES=2, write ADDR=0x0030 data 0x1234 -> SRAM_WE_N low exactly 2 cycles, Data_to_SRAM=0x1234 through HOLD, Ack on cycle 5, Data_to_CPU unchanged.
REQ-044 Hold Req_Rd high for 20 cycles -> exactly one Ack; dropping Req_Rd for 1 cycle and raising it again -> a second access.
REQ-045 Raise Req_Rd and Req_Wr together -> write performed, SRAM_OE_N stays 1 throughout.
REQ-046 Assert Reset during write ACCESS -> next edge SRAM_WE_N=1, Busy=0, no Ack; Req_Wr held through reset -> no access until it is dropped.
REQ-047 With WAIT_STATES=0, read -> Ack 2 cycles after acceptance; write -> SRAM_WE_N low 1 cycle, Ack 4 cycles after acceptance; a bench assertion checks that the strobes are never both low.
